// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction fetch sequencer with ROM wait states and return-address stack
module fetch_sequencer #(
    parameter int AW          = 11,
    parameter int ROM_WAIT    = 1,
    parameter int STACK_DEPTH = 4
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic [6:0]    TYPE,
    input  logic          B1_OUT,
    input  logic [AW-1:0] PC_VAL,
    input  logic          exec_done,
    input  logic          run,
    output logic [AW-1:0] PC,
    output logic [AW-1:0] rom_addr,
    output logic          ir_load,
    output logic          halted,
    output logic          stack_err
);

    // sp counts entries, so it needs one bit more than the entry index to represent "full"
    localparam int              IW        = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int              SPW       = IW + 1;
    localparam logic [SPW-1:0]  SP_FULL   = SPW'(STACK_DEPTH);
    localparam logic [1:0]      WAIT_INIT = (ROM_WAIT > 0) ? 2'(ROM_WAIT - 1) : 2'd0;

    localparam logic [1:0] OP_JUMP = 2'b00;
    localparam logic [1:0] OP_CALL = 2'b01;
    localparam logic [1:0] OP_HALT = 2'b11;

    typedef enum logic [2:0] {
        S_FETCH,
        S_WAIT,
        S_ISSUE,
        S_EXEC,
        S_HALT
    } state_t;

    state_t         state;
    logic [1:0]     wait_cnt;
    logic [SPW-1:0] sp;
    logic [AW-1:0]  stack_mem [STACK_DEPTH];

    logic [AW-1:0]  pc_inc;
    logic [1:0]     op;
    logic           pc_op;
    logic           taken;
    logic           is_halt;
    logic           stack_full;
    logic           stack_empty;
    logic           push_en;
    logic [IW-1:0]  push_idx;
    logic [IW-1:0]  top_idx;
    logic [3:0]     unused_type;

    // Low TYPE bits carry decoder detail that sequencing does not need
    assign unused_type = TYPE[3:0];

    assign pc_inc      = PC + AW'(1);
    assign op          = TYPE[5:4];
    assign pc_op       = TYPE[6];
    assign is_halt     = pc_op && (op == OP_HALT);
    assign taken       = pc_op && B1_OUT;
    assign stack_full  = (sp == SP_FULL);
    assign stack_empty = (sp == '0);
    assign push_idx    = sp[IW-1:0];
    assign top_idx     = IW'(sp - SPW'(1));
    assign push_en     = (state == S_EXEC) && exec_done && !is_halt && taken
                         && (op == OP_CALL) && !stack_full;

    // Return-address storage; contents need no reset because sp gates every read
    always_ff @(posedge clk) begin
        if (push_en) begin
            stack_mem[push_idx] <= pc_inc;
        end
    end

    // Fetch/issue/execute sequencing, next-PC selection and stack pointer
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state     <= S_FETCH;
            wait_cnt  <= 2'd0;
            sp        <= '0;
            PC        <= '0;
            rom_addr  <= '0;
            ir_load   <= 1'b0;
            halted    <= 1'b0;
            stack_err <= 1'b0;
        end else begin
            ir_load <= 1'b0;
            case (state)
                S_FETCH: begin
                    rom_addr <= PC;
                    if (ROM_WAIT > 0) begin
                        wait_cnt <= WAIT_INIT;
                        state    <= S_WAIT;
                    end else begin
                        ir_load <= 1'b1;
                        state   <= S_ISSUE;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == 2'd0) begin
                        ir_load <= 1'b1;
                        state   <= S_ISSUE;
                    end else begin
                        wait_cnt <= wait_cnt - 2'd1;
                    end
                end
                S_ISSUE: begin
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    if (exec_done) begin
                        state <= S_FETCH;
                        if (is_halt) begin
                            PC     <= pc_inc;
                            halted <= 1'b1;
                            state  <= S_HALT;
                        end else if (!taken) begin
                            PC <= pc_inc;
                        end else begin
                            case (op)
                                OP_JUMP: PC <= PC_VAL;
                                OP_CALL: begin
                                    if (!stack_full) begin
                                        sp <= sp + SPW'(1);
                                        PC <= PC_VAL;
                                    end else begin
                                        stack_err <= 1'b1;
                                        PC        <= pc_inc;
                                    end
                                end
                                default: begin
                                    if (!stack_empty) begin
                                        sp <= sp - SPW'(1);
                                        PC <= stack_mem[top_idx];
                                    end else begin
                                        stack_err <= 1'b1;
                                        PC        <= pc_inc;
                                    end
                                end
                            endcase
                        end
                    end
                end
                S_HALT: begin
                    if (run) begin
                        halted <= 1'b0;
                        state  <= S_FETCH;
                    end
                end
                default: begin
                    state <= S_FETCH;
                end
            endcase
        end
    end

endmodule
